mult_lane_pipe: RTL and testbench

//  Parametrised, pipelined successor of the 128-lane FP16 multiplier group. LANES floatMult

---
 rtl/mult_lane_pipe.sv | 155 +++++++++++++++
 tb/tb_mult_lane_pipe.sv | 362 ++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mult_lane_pipe.sv
// mult_lane_pipe: LANES-wide FP16 multiplier feeding a valid/ready pipeline of
// PIPE_STAGES bubble-collapsing register stages. It also provides per-lane
// masking, scalar broadcast of in2 lane 0, and a wrapping count of accepted vectors.
module mult_lane_pipe #(
    parameter int unsigned LANES       = 128,
    parameter int unsigned DATA_W      = 16,
    parameter int unsigned PIPE_STAGES = 2,
    parameter int unsigned CNT_W       = 32
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    in_valid,
    output logic                    in_ready,
    input  logic [LANES*DATA_W-1:0] in1,
    input  logic [LANES*DATA_W-1:0] in2,
    input  logic [LANES-1:0]        lane_mask,
    input  logic                    scalar_md,
    output logic                    out_valid,
    input  logic                    out_ready,
    output logic [LANES*DATA_W-1:0] out,
    output logic [LANES-1:0]        out_mask,
    output logic                    busy,
    output logic [CNT_W-1:0]        op_count
);
    localparam int unsigned VEC_W = LANES * DATA_W;
    localparam int unsigned NST   = PIPE_STAGES;

    // FP16 product with round-to-nearest-even, gradual underflow, overflow to
    // infinity, and canonical quiet NaN for NaN inputs or inf*0.
    function automatic logic [DATA_W-1:0] fp16_mul(input logic [DATA_W-1:0] a,
                                                   input logic [DATA_W-1:0] b);
        logic        sgn;
        logic        a_nan, b_nan, a_inf, b_inf, a_zero, b_zero;
        logic [4:0]  ea, eb;
        logic [10:0] ma, mb;
        logic [21:0] p;
        logic [31:0] pw, q, rem, half, m, res;
        int          lead, e, sh, base;
        logic [DATA_W-1:0] r;
        sgn    = a[15] ^ b[15];
        a_nan  = (a[14:10] == 5'h1F) && (a[9:0] != 10'd0);
        b_nan  = (b[14:10] == 5'h1F) && (b[9:0] != 10'd0);
        a_inf  = (a[14:10] == 5'h1F) && (a[9:0] == 10'd0);
        b_inf  = (b[14:10] == 5'h1F) && (b[9:0] == 10'd0);
        a_zero = (a[14:0] == 15'd0);
        b_zero = (b[14:0] == 15'd0);
        // Subnormals share the exponent of the smallest normal, without the hidden bit.
        ea = (a[14:10] == 5'd0) ? 5'd1 : a[14:10];
        eb = (b[14:10] == 5'd0) ? 5'd1 : b[14:10];
        ma = {(a[14:10] != 5'd0), a[9:0]};
        mb = {(b[14:10] != 5'd0), b[9:0]};
        p  = 22'(ma) * 22'(mb);
        lead = 0;
        for (int i = 0; i < 22; i++) begin
            if (p[i]) lead = i;
        end
        e  = 32'(ea) + 32'(eb);
        // Keep 11 significant bits, or fewer when the result falls into the subnormal range.
        sh = lead - 10;
        if (26 - e > sh) sh = 26 - e;
        base = lead + e - 36;
        if (base < 0) base = 0;
        pw = 32'(p);
        if (sh <= 0) begin
            m = pw << (-sh);
        end else begin
            q    = pw >> sh;
            rem  = pw & ((32'd1 << sh) - 32'd1);
            half = 32'd1 << (sh - 1);
            m    = q;
            if ((rem > half) || ((rem == half) && q[0])) m = q + 32'd1;
        end
        // A mantissa carry-out rolls naturally into the exponent field.
        res = (32'(base) << 10) + m;
        if (a_nan || b_nan || (a_inf && b_zero) || (a_zero && b_inf)) r = 16'h7E00;
        else if (a_inf || b_inf)                                       r = {sgn, 15'h7C00};
        else if (a_zero || b_zero)                                     r = {sgn, 15'd0};
        else if (res >= 32'h7C00)                                      r = {sgn, 15'h7C00};
        else                                                           r = {sgn, res[14:0]};
        return r;
    endfunction

    logic [VEC_W-1:0] prod_c;
    logic [DATA_W-1:0] opb_c;
    logic [NST-1:0]   load_c;
    logic [NST-1:0]   v_q;
    logic [VEC_W-1:0] d_q [NST];
    logic [LANES-1:0] m_q [NST];
    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;
    logic             acc_c;

    // Per-lane masked products of the presented operands.
    always_comb begin
        prod_c = '0;
        opb_c  = '0;
        for (int i = 0; i < int'(LANES); i++) begin
            opb_c = scalar_md ? in2[DATA_W-1:0] : in2[i*DATA_W +: DATA_W];
            if (lane_mask[i]) prod_c[i*DATA_W +: DATA_W] = fp16_mul(in1[i*DATA_W +: DATA_W], opb_c);
        end
    end

    // Stage k may load when downstream will drain or any stage at or above k is empty.
    always_comb begin
        load_c = '0;
        acc_c  = 1'b0;
        for (int k = 0; k < int'(NST); k++) begin
            acc_c = out_ready;
            for (int j = k; j < int'(NST); j++) begin
                acc_c = acc_c | ~v_q[j];
            end
            load_c[k] = acc_c;
        end
    end

    assign cnt_d = cnt_q + CNT_W'(1);

    // Stage registers, valid chain and accept counter.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            v_q   <= '0;
            cnt_q <= '0;
            for (int k = 0; k < int'(NST); k++) begin
                d_q[k] <= '0;
                m_q[k] <= '0;
            end
        end else begin
            if (load_c[0]) begin
                v_q[0] <= in_valid;
                if (in_valid) begin
                    d_q[0] <= prod_c;
                    m_q[0] <= lane_mask;
                end
            end
            for (int k = 1; k < int'(NST); k++) begin
                if (load_c[k]) begin
                    v_q[k] <= v_q[k-1];
                    if (v_q[k-1]) begin
                        d_q[k] <= d_q[k-1];
                        m_q[k] <= m_q[k-1];
                    end
                end
            end
            if (in_valid && load_c[0]) cnt_q <= cnt_d;
        end
    end

    assign in_ready  = load_c[0];
    assign out_valid = v_q[NST-1];
    assign out       = d_q[NST-1];
    assign out_mask  = m_q[NST-1];
    assign busy      = |v_q;
    assign op_count  = cnt_q;

endmodule

// File: tb/tb_mult_lane_pipe.sv
// Bench for mult_lane_pipe: a real-arithmetic FP16 reference with a transaction queue
// predicts every output, handshake and counter cycle by cycle.
module tb_mult_lane_pipe;
    localparam int L1 = 16;
    localparam int P1 = 2;
    localparam int L2 = 2;
    localparam int P2 = 3;
    localparam int MAXW = L1 * 16;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    logic             iv1 = 1'b0, ir1, sc1 = 1'b0, ov1, or1 = 1'b1, busy1;
    logic [L1*16-1:0] a1 = '0, b1 = '0, out1;
    logic [L1-1:0]    m1 = '0, om1;
    logic [31:0]      opc1;

    logic             iv2 = 1'b0, ir2, sc2 = 1'b0, ov2, or2 = 1'b1, busy2;
    logic [L2*16-1:0] a2 = '0, b2 = '0, out2;
    logic [L2-1:0]    m2 = '0, om2;
    logic [3:0]       opc2;

    mult_lane_pipe #(.LANES(L1), .DATA_W(16), .PIPE_STAGES(P1), .CNT_W(32)) dut1 (
        .clk(clk), .rst(rst), .in_valid(iv1), .in_ready(ir1), .in1(a1), .in2(b1),
        .lane_mask(m1), .scalar_md(sc1), .out_valid(ov1), .out_ready(or1), .out(out1),
        .out_mask(om1), .busy(busy1), .op_count(opc1));

    mult_lane_pipe #(.LANES(L2), .DATA_W(16), .PIPE_STAGES(P2), .CNT_W(4)) dut2 (
        .clk(clk), .rst(rst), .in_valid(iv2), .in_ready(ir2), .in1(a2), .in2(b2),
        .lane_mask(m2), .scalar_md(sc2), .out_valid(ov2), .out_ready(or2), .out(out2),
        .out_mask(om2), .busy(busy2), .op_count(opc2));

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    int nout1 = 0;
    int acc1 = 0, acc2 = 0;

    typedef struct {
        logic [MAXW-1:0] d;
        logic [15:0]     m;
        int              t;
    } exp_t;
    exp_t q1[$];
    exp_t q2[$];

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk32(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s act=%h exp=%h t=%0t", name, act, exp, $time);
        end
    endtask

    task automatic chkv(input string name, input logic [MAXW-1:0] act, input logic [MAXW-1:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s act=%h exp=%h t=%0t", name, act, exp, $time);
        end
    endtask

    // Value of an FP16 encoding as a real number.
    function automatic real h2r(input logic [15:0] h);
        int ex, fr;
        ex = int'(h[14:10]);
        fr = int'(h[9:0]);
        if (ex == 0) return real'(fr) * (2.0 ** -24);
        return real'(1024 + fr) * (2.0 ** (ex - 25));
    endfunction

    // Nearest-even FP16 magnitude encoding of a non-negative real (saturates to inf).
    function automatic logic [14:0] round_mag(input real x);
        int     ex, bits;
        real    qu, n, fl;
        longint fi;
        if (x == 0.0) return 15'd0;
        ex = 0;
        while (x >= 2.0 ** (ex + 1)) ex++;
        while (x < 2.0 ** ex) ex--;
        qu = (ex < -14) ? (2.0 ** -24) : (2.0 ** (ex - 10));
        n  = x / qu;
        fl = $floor(n);
        fi = longint'(fl);
        if (((n - fl) > 0.5) || (((n - fl) == 0.5) && fi[0])) fi++;
        if (ex < -14) bits = int'(fi);
        else          bits = (ex + 14) * 1024 + int'(fi);
        if (bits >= 32'h7C00) bits = 32'h7C00;
        return 15'(bits);
    endfunction

    function automatic logic [15:0] ref_mul(input logic [15:0] a, input logic [15:0] b);
        logic an, bn, ai, bi, az, bz, s;
        an = (a[14:10] == 5'h1F) && (a[9:0] != 10'd0);
        bn = (b[14:10] == 5'h1F) && (b[9:0] != 10'd0);
        ai = (a[14:10] == 5'h1F) && (a[9:0] == 10'd0);
        bi = (b[14:10] == 5'h1F) && (b[9:0] == 10'd0);
        az = (a[14:0] == 15'd0);
        bz = (b[14:0] == 15'd0);
        if (an || bn || (ai && bz) || (az && bi)) return 16'h7E00;
        s = a[15] ^ b[15];
        if (ai || bi) return {s, 15'h7C00};
        return {s, round_mag(h2r(a) * h2r(b))};
    endfunction

    function automatic logic [MAXW-1:0] exp_vec(input logic [MAXW-1:0] a, input logic [MAXW-1:0] b,
                                                input logic [15:0] m, input logic sc, input int lanes);
        logic [MAXW-1:0] r;
        logic [15:0]     bb;
        r = '0;
        for (int i = 0; i < lanes; i++) begin
            bb = sc ? b[15:0] : b[i*16 +: 16];
            if (m[i]) r[i*16 +: 16] = ref_mul(a[i*16 +: 16], bb);
        end
        return r;
    endfunction

    function automatic logic [15:0] rand_half();
        logic [15:0] h;
        h = 16'($urandom);
        if ($urandom_range(0, 1) == 0) h[14:10] = 5'(10 + $urandom_range(0, 10));
        return h;
    endfunction

    // Single compare process: model occupancy, latency, handshakes, counters, data.
    always @(negedge clk) begin
        exp_t e;
        bit   eov, eir;
        if (rst) begin
            q1.delete();
            q2.delete();
            acc1 = 0;
            acc2 = 0;
            chk32("rst_out_valid1", 32'(ov1), 32'd0);
            chk32("rst_busy1", 32'(busy1), 32'd0);
            chk32("rst_op_count1", opc1, 32'd0);
            chkv("rst_out1", out1, '0);
            chk32("rst_op_count2", 32'(opc2), 32'd0);
        end else begin
            eov = (q1.size() > 0) && (cyc >= q1[0].t + P1 - 1);
            eir = or1 || (q1.size() < P1);
            chk32("out_valid1", 32'(ov1), 32'(eov));
            chk32("in_ready1", 32'(ir1), 32'(eir));
            chk32("busy1", 32'(busy1), 32'(q1.size() > 0));
            chk32("op_count1", opc1, 32'(acc1));
            if (eov) begin
                chkv("out1", out1, q1[0].d);
                chk32("out_mask1", 32'(om1), 32'(q1[0].m));
                if (or1) begin
                    void'(q1.pop_front());
                    nout1++;
                end
            end
            if (iv1 && eir) begin
                e.d = exp_vec(a1, b1, 16'(m1), sc1, L1);
                e.m = 16'(m1);
                e.t = cyc + 1;
                q1.push_back(e);
                acc1++;
            end

            eov = (q2.size() > 0) && (cyc >= q2[0].t + P2 - 1);
            eir = or2 || (q2.size() < P2);
            chk32("out_valid2", 32'(ov2), 32'(eov));
            chk32("in_ready2", 32'(ir2), 32'(eir));
            chk32("op_count2", 32'(opc2), 32'(acc2 % 16));
            if (eov) begin
                chkv("out2", MAXW'(out2), q2[0].d);
                chk32("out_mask2", 32'(om2), 32'(q2[0].m));
                if (or2) void'(q2.pop_front());
            end
            if (iv2 && eir) begin
                e.d = exp_vec(MAXW'(a2), MAXW'(b2), 16'(m2), sc2, L2);
                e.m = 16'(m2);
                e.t = cyc + 1;
                q2.push_back(e);
                acc2++;
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic rand_in1();
        for (int i = 0; i < L1; i++) begin
            a1[i*16 +: 16] = rand_half();
            b1[i*16 +: 16] = rand_half();
        end
        m1  = L1'($urandom);
        sc1 = ($urandom_range(0, 3) == 0);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog timeout t=%0t", $time);
        $fatal(1, "timeout");
    end

    initial begin
        logic [MAXW-1:0] ev;
        logic [15:0] sa [16];
        logic [15:0] sb [16];
        int sent, c, hs, n0;
        logic [31:0] opc_before;
        bit saw_stall, acc_now;

        // Hand-computed pins on the reference model.
        chk32("model_1p5x2", 32'(ref_mul(16'h3E00, 16'h4000)), 32'h4200);
        chk32("model_1xm2", 32'(ref_mul(16'h3C00, 16'hC000)), 32'hC000);
        chk32("model_infx0", 32'(ref_mul(16'h7C00, 16'h0000)), 32'h7E00);
        chk32("model_ovf", 32'(ref_mul(16'h7BFF, 16'h4000)), 32'h7C00);
        chk32("model_sub_tie", 32'(ref_mul(16'h0001, 16'h3800)), 32'h0000);
        chk32("model_sub_up", 32'(ref_mul(16'h0001, 16'h3E00)), 32'h0002);

        repeat (3) step();
        rst = 1'b0;
        step();

        // Basic product and latency.
        a1 = {L1{16'h3E00}}; b1 = {L1{16'h4000}}; m1 = '1; sc1 = 1'b0; iv1 = 1'b1;
        step();
        iv1 = 1'b0;
        chk32("basic_not_early", 32'(ov1), 32'd0);
        step();
        chk32("basic_valid", 32'(ov1), 32'd1);
        chkv("basic_out", out1, {L1{16'h4200}});
        repeat (2) step();

        // Scalar broadcast with alternating mask.
        for (int i = 0; i < L1; i++) begin
            a1[i*16 +: 16] = 16'h3C00;
            b1[i*16 +: 16] = 16'($urandom);
        end
        b1[15:0] = 16'hC000;
        m1 = 16'h5555; sc1 = 1'b1; iv1 = 1'b1;
        step();
        iv1 = 1'b0;
        step();
        ev = '0;
        for (int i = 0; i < L1; i += 2) ev[i*16 +: 16] = 16'hC000;
        chkv("scalar_out", out1, ev);
        chk32("scalar_mask", 32'(om1), 32'h5555);
        repeat (2) step();

        // Special operands through the model.
        sa = '{16'h7C00, 16'h7C00, 16'h7E00, 16'h0000, 16'h7BFF, 16'h0001, 16'h0001, 16'h03FF,
               16'h3C00, 16'h8000, 16'hFC00, 16'h0400, 16'h3555, 16'h3800, 16'h7BFF, 16'h0200};
        sb = '{16'h0000, 16'hC000, 16'h3C00, 16'h8000, 16'h4000, 16'h3800, 16'h3E00, 16'h3C01,
               16'h3C00, 16'h3C00, 16'hFC00, 16'h3800, 16'h3555, 16'h0001, 16'hBC00, 16'h0200};
        for (int i = 0; i < L1; i++) begin
            a1[i*16 +: 16] = sa[i];
            b1[i*16 +: 16] = sb[i];
        end
        m1 = '1; sc1 = 1'b0; iv1 = 1'b1;
        step();
        iv1 = 1'b0;
        repeat (3) step();

        // Randomised traffic with random backpressure.
        for (int k = 0; k < 400; k++) begin
            rand_in1();
            iv1 = ($urandom_range(0, 9) < 7);
            or1 = ($urandom_range(0, 9) < 7);
            step();
        end
        iv1 = 1'b0; or1 = 1'b1;
        repeat (P1 + 2) step();

        // Tagged stream with a 5-cycle downstream stall.
        n0 = nout1; sent = 0; c = 0; saw_stall = 1'b0;
        m1 = '1; sc1 = 1'b0; b1 = {L1{16'h3C00}};
        while (sent < 10 && c < 100) begin
            or1 = !(c >= 3 && c < 8);
            for (int i = 0; i < L1; i++) a1[i*16 +: 16] = rand_half();
            a1[15:0] = 16'(sent);
            iv1 = 1'b1;
            @(negedge clk);
            if (!ir1) saw_stall = 1'b1;
            acc_now = ir1;
            step();
            if (acc_now) sent++;
            c++;
        end
        iv1 = 1'b0; or1 = 1'b1;
        repeat (P1 + 2) step();
        chk32("bp_sent", 32'(sent), 32'd10);
        chk32("bp_stalled", 32'(saw_stall), 32'd1);
        chk32("bp_outputs", 32'(nout1 - n0), 32'd10);
        chk32("bp_drained", 32'(q1.size()), 32'd0);

        // Reset with two vectors in flight.
        or1 = 1'b0; iv1 = 1'b1; rand_in1();
        step();
        rand_in1();
        step();
        iv1 = 1'b0;
        chk32("pre_rst_busy", 32'(busy1), 32'd1);
        rst = 1'b1;
        #1;
        chk32("rst_now_valid", 32'(ov1), 32'd0);
        chk32("rst_now_busy", 32'(busy1), 32'd0);
        chk32("rst_now_count", opc1, 32'd0);
        step();
        rst = 1'b0; or1 = 1'b1;
        rand_in1(); iv1 = 1'b1;
        step();
        iv1 = 1'b0;
        chk32("post_rst_count", opc1, 32'd1);
        repeat (P1 + 2) step();

        // Full pipe, continuous accept and emit.
        rst = 1'b1;
        step();
        rst = 1'b0;
        or1 = 1'b0; iv1 = 1'b1;
        for (int k = 0; k < P1; k++) begin
            rand_in1();
            step();
        end
        or1 = 1'b1;
        opc_before = opc1;
        hs = 0;
        for (int k = 0; k < 100; k++) begin
            rand_in1();
            @(negedge clk);
            if (ov1 && ir1) hs++;
            step();
        end
        iv1 = 1'b0;
        chk32("tp_handshakes", 32'(hs), 32'd100);
        chk32("tp_op_count", opc1 - opc_before, 32'd100);
        repeat (P1 + 2) step();

        // Four-bit counter wrap on the second instance.
        for (int k = 0; k < 17; k++) begin
            for (int i = 0; i < L2; i++) begin
                a2[i*16 +: 16] = rand_half();
                b2[i*16 +: 16] = rand_half();
            end
            m2 = L2'($urandom);
            sc2 = ($urandom_range(0, 1) == 0);
            iv2 = 1'b1;
            step();
            if (k == 14) chk32("wrap_15", 32'(opc2), 32'd15);
            if (k == 15) chk32("wrap_0", 32'(opc2), 32'd0);
            if (k == 16) chk32("wrap_1", 32'(opc2), 32'd1);
        end
        iv2 = 1'b0;
        repeat (P2 + 2) step();
        chk32("end_q1_empty", 32'(q1.size()), 32'd0);
        chk32("end_q2_empty", 32'(q2.size()), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
